// File: rtl/uart_packet_decoder_pkg.sv
// Shared constants and types for the debug packet link (decoder and encoder sides).
package uart_packet_decoder_pkg;

  localparam logic [7:0] PktSync = 8'hA5;

  typedef enum logic [1:0] {
    KindReg   = 2'b00,
    KindAlu   = 2'b01,
    KindInst  = 2'b10,
    KindOther = 2'b11
  } pkt_kind_e;

  typedef enum logic [1:0] {
    ErrNone = 2'b00,
    ErrChk  = 2'b01,
    ErrHdr  = 2'b10,
    ErrTmo  = 2'b11
  } err_code_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StHdr  = 2'b01,
    StData = 2'b10,
    StChk  = 2'b11
  } state_e;

endpackage

// File: rtl/uart_packet_decoder_if.sv
// Byte-in / packet-out bundle between the UART receiver side and the packet consumers.
interface uart_packet_decoder_if #(
  parameter int unsigned PKT_CNT_W = 16
);
  logic                 rx_done;
  logic [7:0]           rx_data;
  logic                 pkt_valid;
  logic [1:0]           pkt_kind;
  logic [4:0]           pkt_addr;
  logic [31:0]          pkt_data;
  logic                 err_strobe;
  logic [1:0]           err_code;
  logic [PKT_CNT_W-1:0] pkt_count;
  logic [7:0]           err_count;

  modport master (
    output rx_done, rx_data,
    input  pkt_valid, pkt_kind, pkt_addr, pkt_data,
    input  err_strobe, err_code, pkt_count, err_count
  );

  modport slave (
    input  rx_done, rx_data,
    output pkt_valid, pkt_kind, pkt_addr, pkt_data,
    output err_strobe, err_code, pkt_count, err_count
  );
endinterface

// File: rtl/uart_packet_decoder_pkt_byte_timer.sv
// Inter-byte timeout counter: runs while enabled, cleared by each received byte.
module uart_packet_decoder_pkt_byte_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 166624,
  parameter int unsigned CNT_W          = 18
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A byte on the threshold cycle wins over the timeout.
  always_comb begin
    expire_o = enable_i && !clear_i && (cnt_q == CntLast);
    cnt_d    = cnt_q + CNT_W'(1);
    if (!enable_i || clear_i || expire_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_packet_decoder.sv
// Reassembles 7-byte SYNC/HDR/DATA/CHK frames into checked debug packets.
module uart_packet_decoder
  import uart_packet_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 166624,
  parameter int unsigned CNT_W          = 18,
  parameter int unsigned PKT_CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_packet_decoder_if.slave  bus_io
);

  state_e               state_q, state_d;
  logic [1:0]           byte_idx_q, byte_idx_d;
  logic [1:0]           hdr_kind_q, hdr_kind_d;
  logic [4:0]           hdr_addr_q, hdr_addr_d;
  logic [31:0]          data_sh_q, data_sh_d;
  logic [7:0]           chk_acc_q, chk_acc_d;

  logic                 pkt_valid_q, pkt_valid_d;
  logic [1:0]           pkt_kind_q, pkt_kind_d;
  logic [4:0]           pkt_addr_q, pkt_addr_d;
  logic [31:0]          pkt_data_q, pkt_data_d;
  logic                 err_strobe_q, err_strobe_d;
  logic [1:0]           err_code_q, err_code_d;
  logic [PKT_CNT_W-1:0] pkt_count_q, pkt_count_d;
  logic [7:0]           err_count_q, err_count_d;

  logic                 tmo;
  logic                 err_evt;
  logic [1:0]           err_sel;
  logic [7:0]           rx_byte;

  assign rx_byte = bus_io.rx_data;

  uart_packet_decoder_pkt_byte_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clk_i    (clk),
    .rst_i    (reset),
    .clear_i  (bus_io.rx_done),
    .enable_i (state_q != StIdle),
    .expire_o (tmo)
  );

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    hdr_kind_d  = hdr_kind_q;
    hdr_addr_d  = hdr_addr_q;
    data_sh_d   = data_sh_q;
    chk_acc_d   = chk_acc_q;
    pkt_valid_d = 1'b0;
    pkt_kind_d  = pkt_kind_q;
    pkt_addr_d  = pkt_addr_q;
    pkt_data_d  = pkt_data_q;
    pkt_count_d = pkt_count_q;
    err_evt     = 1'b0;
    err_sel     = ErrNone;

    if (tmo) begin
      state_d = StIdle;
      err_evt = 1'b1;
      err_sel = ErrTmo;
    end else if (bus_io.rx_done) begin
      unique case (state_q)
        StIdle: begin
          if (rx_byte == PktSync) state_d = StHdr;
        end
        StHdr: begin
          if (!rx_byte[7]) begin
            hdr_kind_d = rx_byte[6:5];
            hdr_addr_d = rx_byte[4:0];
            chk_acc_d  = rx_byte;
            byte_idx_d = 2'd0;
            state_d    = StData;
          end else if (rx_byte != PktSync) begin
            err_evt = 1'b1;
            err_sel = ErrHdr;
            state_d = StIdle;
          end
        end
        StData: begin
          data_sh_d  = {data_sh_q[23:0], rx_byte};
          chk_acc_d  = chk_acc_q ^ rx_byte;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) state_d = StChk;
        end
        StChk: begin
          if (rx_byte == chk_acc_q) begin
            pkt_valid_d = 1'b1;
            pkt_kind_d  = hdr_kind_q;
            pkt_addr_d  = hdr_addr_q;
            pkt_data_d  = data_sh_q;
            pkt_count_d = pkt_count_q + PKT_CNT_W'(1);
          end else begin
            err_evt = 1'b1;
            err_sel = ErrChk;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    err_strobe_d = err_evt;
    err_code_d   = err_evt ? err_sel : err_code_q;
    err_count_d  = err_count_q;
    if (err_evt && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      byte_idx_q   <= '0;
      hdr_kind_q   <= '0;
      hdr_addr_q   <= '0;
      data_sh_q    <= '0;
      chk_acc_q    <= '0;
      pkt_valid_q  <= 1'b0;
      pkt_kind_q   <= '0;
      pkt_addr_q   <= '0;
      pkt_data_q   <= '0;
      err_strobe_q <= 1'b0;
      err_code_q   <= '0;
      pkt_count_q  <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      hdr_kind_q   <= hdr_kind_d;
      hdr_addr_q   <= hdr_addr_d;
      data_sh_q    <= data_sh_d;
      chk_acc_q    <= chk_acc_d;
      pkt_valid_q  <= pkt_valid_d;
      pkt_kind_q   <= pkt_kind_d;
      pkt_addr_q   <= pkt_addr_d;
      pkt_data_q   <= pkt_data_d;
      err_strobe_q <= err_strobe_d;
      err_code_q   <= err_code_d;
      pkt_count_q  <= pkt_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus_io.pkt_valid  = pkt_valid_q;
  assign bus_io.pkt_kind   = pkt_kind_q;
  assign bus_io.pkt_addr   = pkt_addr_q;
  assign bus_io.pkt_data   = pkt_data_q;
  assign bus_io.err_strobe = err_strobe_q;
  assign bus_io.err_code   = err_code_q;
  assign bus_io.pkt_count  = pkt_count_q;
  assign bus_io.err_count  = err_count_q;

endmodule

// File: tb/tb_uart_packet_decoder.sv
// Directed bench for uart_packet_decoder; short timeout and narrow packet counter keep runs small.
module tb_uart_packet_decoder;
  import uart_packet_decoder_pkg::*;

  localparam int unsigned Tmo     = 40;
  localparam int unsigned CntW    = 6;
  localparam int unsigned PktCntW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_valid = 0;
  int   n_err = 0;
  int   n_both = 0;

  always #5 clk = ~clk;

  uart_packet_decoder_if #(.PKT_CNT_W(PktCntW)) bus ();

  uart_packet_decoder #(
    .TIMEOUT_CYCLES (Tmo),
    .CNT_W          (CntW),
    .PKT_CNT_W      (PktCntW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus.slave)
  );

  always @(negedge clk) begin
    if (bus.pkt_valid === 1'b1) n_valid++;
    if (bus.err_strobe === 1'b1) n_err++;
    if (bus.pkt_valid === 1'b1 && bus.err_strobe === 1'b1) n_both++;
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [31:0] d, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(hdr);
    send_byte(d[31:24]);
    send_byte(d[23:16]);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
    send_byte(chk);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_pkt(input string name, input logic [1:0] kind, input logic [4:0] addr,
                           input logic [31:0] data, input logic [PktCntW-1:0] cnt);
    n_checks++;
    if (bus.pkt_valid !== 1'b1 || bus.err_strobe !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_valid got v=%b e=%b exp v=1 e=0", name, bus.pkt_valid, bus.err_strobe);
    end
    n_checks++;
    if ({bus.pkt_kind, bus.pkt_addr, bus.pkt_data} !== {kind, addr, data}) begin
      n_errors++;
      $display("FAIL %s_fields got %h/%h/%h exp %h/%h/%h", name, bus.pkt_kind, bus.pkt_addr,
               bus.pkt_data, kind, addr, data);
    end
    n_checks++;
    if (bus.pkt_count !== cnt) begin
      n_errors++;
      $display("FAIL %s_count got %0d exp %0d", name, bus.pkt_count, cnt);
    end
  endtask

  task automatic test_reset();
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    n_checks++;
    if ({bus.pkt_valid, bus.pkt_kind, bus.pkt_addr, bus.pkt_data, bus.err_strobe, bus.err_code,
         bus.err_count, bus.pkt_count} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs got nonzero (data=%h cnt=%0d) exp 0", bus.pkt_data,
               bus.pkt_count);
    end
  endtask

  task automatic test_good_frame();
    send_frame(8'h23, 32'h1234_5678, 8'h2B);
    check_pkt("good", KindAlu, 5'h03, 32'h1234_5678, PktCntW'(1));
    wait_cycles(1);
    n_checks++;
    if (bus.pkt_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL good_strobe_width got %b exp 0", bus.pkt_valid);
    end
  endtask

  task automatic test_bad_checksum();
    send_frame(8'h23, 32'h1234_5678, 8'h2A);
    n_checks++;
    if ({bus.err_strobe, bus.err_code, bus.err_count, bus.pkt_valid} !== {1'b1, ErrChk, 8'd1, 1'b0})
    begin
      n_errors++;
      $display("FAIL chk_err got s=%b c=%b n=%0d v=%b exp s=1 c=01 n=1 v=0", bus.err_strobe,
               bus.err_code, bus.err_count, bus.pkt_valid);
    end
    n_checks++;
    if ({bus.pkt_kind, bus.pkt_addr, bus.pkt_data, bus.pkt_count} !==
        {KindAlu, 5'h03, 32'h1234_5678, PktCntW'(1)}) begin
      n_errors++;
      $display("FAIL chk_hold got %h/%h/%h/%0d", bus.pkt_kind, bus.pkt_addr, bus.pkt_data,
               bus.pkt_count);
    end
  endtask

  task automatic test_resync();
    logic [7:0] seq [10] = '{8'h00, 8'hFF, 8'hA5, 8'hA5, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                             8'h27};
    for (int i = 0; i < 10; i++) send_byte(seq[i]);
    check_pkt("resync", KindReg, 5'h05, 32'hDEAD_BEEF, PktCntW'(2));
    n_checks++;
    if (bus.err_count !== 8'd1) begin
      n_errors++;
      $display("FAIL resync_noerr got err_count=%0d exp 1", bus.err_count);
    end
  endtask

  task automatic test_timeout();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h11);
    wait_cycles(Tmo - 1);
    n_checks++;
    if (bus.err_strobe !== 1'b0) begin
      n_errors++;
      $display("FAIL tmo_early got err_strobe=%b exp 0", bus.err_strobe);
    end
    wait_cycles(1);
    n_checks++;
    if ({bus.err_strobe, bus.err_code, bus.err_count} !== {1'b1, ErrTmo, 8'd2}) begin
      n_errors++;
      $display("FAIL tmo_err got s=%b c=%b n=%0d exp s=1 c=11 n=2", bus.err_strobe,
               bus.err_code, bus.err_count);
    end
    wait_cycles(Tmo + 10);
    n_checks++;
    if (bus.err_count !== 8'd2) begin
      n_errors++;
      $display("FAIL tmo_once got err_count=%0d exp 2", bus.err_count);
    end
    send_frame(8'h41, 32'h0102_0304, 8'h45);
    check_pkt("tmo_next", KindInst, 5'h01, 32'h0102_0304, PktCntW'(3));
  endtask

  task automatic test_threshold();
    send_byte(8'hA5);
    send_byte(8'h63);
    send_byte(8'hAA);
    wait_cycles(Tmo - 1);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    send_byte(8'h63);
    check_pkt("thresh", KindOther, 5'h03, 32'hAABB_CCDD, PktCntW'(4));
    n_checks++;
    if (bus.err_count !== 8'd2) begin
      n_errors++;
      $display("FAIL thresh_noerr got err_count=%0d exp 2", bus.err_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0;
    #1;
    v0 = n_valid;
    e0 = n_err;
    send_byte(8'hA5);
    send_byte(8'h23);
    send_byte(8'h12);
    send_byte(8'h34);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    n_checks++;
    if ({bus.pkt_valid, bus.pkt_kind, bus.pkt_addr, bus.pkt_data, bus.err_strobe, bus.err_code,
         bus.err_count, bus.pkt_count} !== '0) begin
      n_errors++;
      $display("FAIL midrst_outputs got nonzero (data=%h cnt=%0d err=%0d) exp 0", bus.pkt_data,
               bus.pkt_count, bus.err_count);
    end
    send_byte(8'h56);
    send_byte(8'h78);
    send_byte(8'h2B);
    wait_cycles(2);
    #1;
    n_checks++;
    if (n_valid != v0 || n_err != e0) begin
      n_errors++;
      $display("FAIL midrst_quiet got valid+%0d err+%0d exp +0 +0", n_valid - v0, n_err - e0);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    #1;
    v0 = n_valid;
    for (int i = 0; i < (1 << PktCntW) + 1; i++) send_frame(8'h23, 32'h1234_5678, 8'h2B);
    check_pkt("b2b", KindAlu, 5'h03, 32'h1234_5678, PktCntW'(1));
    #1;
    n_checks++;
    if (n_valid - v0 != (1 << PktCntW) + 1) begin
      n_errors++;
      $display("FAIL b2b_strobes got %0d exp %0d", n_valid - v0, (1 << PktCntW) + 1);
    end
  endtask

  task automatic test_err_saturate();
    int e0;
    #1;
    e0 = n_err;
    for (int i = 0; i < 300; i++) begin
      send_byte(8'hA5);
      send_byte(8'h80);
    end
    n_checks++;
    if ({bus.err_strobe, bus.err_code, bus.err_count} !== {1'b1, ErrHdr, 8'hFF}) begin
      n_errors++;
      $display("FAIL hdr_sat got s=%b c=%b n=%0d exp s=1 c=10 n=255", bus.err_strobe,
               bus.err_code, bus.err_count);
    end
    #1;
    n_checks++;
    if (n_err - e0 != 300) begin
      n_errors++;
      $display("FAIL hdr_strobes got %0d exp 300", n_err - e0);
    end
    n_checks++;
    if (n_both != 0) begin
      n_errors++;
      $display("FAIL exclusive got %0d overlapping cycles exp 0", n_both);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_resync();
    test_timeout();
    test_threshold();
    test_reset_mid_frame();
    test_back_to_back();
    test_err_saturate();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
